// File: rtl/rocc_mem_replay_buf.sv
// rocc_mem_replay_buf
// Replay buffer between the vv_add accelerator memory port and the L1 data
// cache. Each accepted request is parked in an entry whose index becomes the
// cache tag. Nacked requests are re-issued from the entry with identical
// fields. Good responses are mapped back to the accelerator's original tag
// and command, and the entry is then retired.

module rocc_mem_replay_buf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 40,
  parameter int TAG_W  = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              acc_req_valid_i,
  output logic              acc_req_ready_o,
  input  logic [ADDR_W-1:0] acc_req_addr_i,
  input  logic [TAG_W-1:0]  acc_req_tag_i,
  input  logic [4:0]        acc_req_cmd_i,
  input  logic [2:0]        acc_req_typ_i,
  input  logic              acc_req_phys_i,
  input  logic [DATA_W-1:0] acc_req_data_i,

  output logic              cache_req_valid_o,
  input  logic              cache_req_ready_i,
  output logic [ADDR_W-1:0] cache_req_addr_o,
  output logic [TAG_W-1:0]  cache_req_tag_o,
  output logic [4:0]        cache_req_cmd_o,
  output logic [2:0]        cache_req_typ_o,
  output logic              cache_req_phys_o,
  output logic [DATA_W-1:0] cache_req_data_o,

  input  logic              cache_resp_valid_i,
  input  logic              cache_resp_nack_i,
  input  logic [TAG_W-1:0]  cache_resp_tag_i,
  input  logic              cache_resp_has_data_i,
  input  logic [DATA_W-1:0] cache_resp_data_i,

  output logic              acc_resp_valid_o,
  output logic [TAG_W-1:0]  acc_resp_tag_o,
  output logic [4:0]        acc_resp_cmd_o,
  output logic              acc_resp_has_data_o,
  output logic [DATA_W-1:0] acc_resp_data_o,

  output logic              busy_o,
  output logic [15:0]       nack_cnt_o,
  output logic              err_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Per-entry control bits
  logic [DEPTH-1:0] busy_q, pend_q;
  logic [DEPTH-1:0] busy_d, pend_d;

  // Per-entry captured request payload
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [4:0]        cmd_q  [DEPTH];
  logic [2:0]        typ_q  [DEPTH];
  logic [DEPTH-1:0]  phys_q;
  logic [DATA_W-1:0] data_q [DEPTH];

  logic             any_free, any_pend;
  logic [IDX_W-1:0] alloc_idx, issue_idx, resp_idx;
  logic             alloc_fire, issue_fire;
  logic             idx_in_range, target_ok;
  logic             resp_ok, nack_ok, bad_event;

  // Lowest-index free entry for allocation and lowest-index pending entry for issue
  always_comb begin
    any_free  = 1'b0;
    alloc_idx = '0;
    any_pend  = 1'b0;
    issue_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        any_free  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      if (pend_q[i]) begin
        any_pend  = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  // Ready comes from registered occupancy only; held low while in reset
  assign acc_req_ready_o = any_free & ~rst;
  assign alloc_fire      = acc_req_valid_i & acc_req_ready_o;

  // Cache request side is a pure mux of registered entry state, zeroed when idle
  assign cache_req_valid_o = any_pend;
  assign issue_fire        = any_pend & cache_req_ready_i;
  assign cache_req_addr_o  = any_pend ? addr_q[issue_idx] : '0;
  assign cache_req_tag_o   = any_pend ? TAG_W'(issue_idx) : '0;
  assign cache_req_cmd_o   = any_pend ? cmd_q[issue_idx]  : '0;
  assign cache_req_typ_o   = any_pend ? typ_q[issue_idx]  : '0;
  assign cache_req_phys_o  = any_pend & phys_q[issue_idx];
  assign cache_req_data_o  = any_pend ? data_q[issue_idx] : '0;

  // A response or nack is only legal for an in-range entry that is in flight
  assign resp_idx     = cache_resp_tag_i[IDX_W-1:0];
  assign idx_in_range = ({1'b0, cache_resp_tag_i} < (TAG_W + 1)'(DEPTH));
  assign target_ok    = idx_in_range & busy_q[resp_idx] & ~pend_q[resp_idx];
  assign resp_ok      = cache_resp_valid_i & ~cache_resp_nack_i & target_ok;
  assign nack_ok      = cache_resp_nack_i & target_ok;
  assign bad_event    = (cache_resp_valid_i | cache_resp_nack_i) & ~target_ok;

  assign busy_o = |busy_q;

  // Next entry state: allocation, issue, retire and replay always hit distinct entries
  always_comb begin
    busy_d = busy_q;
    pend_d = pend_q;
    if (alloc_fire) begin
      busy_d[alloc_idx] = 1'b1;
      pend_d[alloc_idx] = 1'b1;
    end
    if (issue_fire) begin
      pend_d[issue_idx] = 1'b0;
    end
    if (resp_ok) begin
      busy_d[resp_idx] = 1'b0;
    end
    if (nack_ok) begin
      pend_d[resp_idx] = 1'b1;
    end
  end

  // Entry control bits, response pulse, nack counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q              <= '0;
      pend_q              <= '0;
      acc_resp_valid_o    <= 1'b0;
      acc_resp_tag_o      <= '0;
      acc_resp_cmd_o      <= '0;
      acc_resp_has_data_o <= 1'b0;
      acc_resp_data_o     <= '0;
      nack_cnt_o          <= '0;
      err_o               <= 1'b0;
    end else begin
      busy_q           <= busy_d;
      pend_q           <= pend_d;
      acc_resp_valid_o <= resp_ok;
      if (resp_ok) begin
        acc_resp_tag_o      <= tag_q[resp_idx];
        acc_resp_cmd_o      <= cmd_q[resp_idx];
        acc_resp_has_data_o <= cache_resp_has_data_i;
        acc_resp_data_o     <= cache_resp_data_i;
      end else begin
        acc_resp_tag_o      <= '0;
        acc_resp_cmd_o      <= '0;
        acc_resp_has_data_o <= 1'b0;
        acc_resp_data_o     <= '0;
      end
      if (nack_ok && (nack_cnt_o != 16'hFFFF)) begin
        nack_cnt_o <= nack_cnt_o + 16'd1;
      end
      if (bad_event) begin
        err_o <= 1'b1;
      end
    end
  end

  // Payload capture on allocation; contents only matter while the entry is busy
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      addr_q[alloc_idx] <= acc_req_addr_i;
      tag_q[alloc_idx]  <= acc_req_tag_i;
      cmd_q[alloc_idx]  <= acc_req_cmd_i;
      typ_q[alloc_idx]  <= acc_req_typ_i;
      phys_q[alloc_idx] <= acc_req_phys_i;
      data_q[alloc_idx] <= acc_req_data_i;
    end
  end

endmodule

// File: tb/tb_rocc_mem_replay_buf.sv
// tb_rocc_mem_replay_buf
// Randomized bench for the replay buffer. The driver plays both vv_add and
// the cache, keeps a reference model of the entries and pushes expected
// outputs into queues; a monitor pops and compares on every falling edge.

module tb_rocc_mem_replay_buf;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 40;
  localparam int TAG_W  = 10;
  localparam int DATA_W = 64;

  logic              clk, rst;
  logic              acc_req_valid_i, acc_req_ready_o;
  logic [ADDR_W-1:0] acc_req_addr_i;
  logic [TAG_W-1:0]  acc_req_tag_i;
  logic [4:0]        acc_req_cmd_i;
  logic [2:0]        acc_req_typ_i;
  logic              acc_req_phys_i;
  logic [DATA_W-1:0] acc_req_data_i;
  logic              cache_req_valid_o, cache_req_ready_i;
  logic [ADDR_W-1:0] cache_req_addr_o;
  logic [TAG_W-1:0]  cache_req_tag_o;
  logic [4:0]        cache_req_cmd_o;
  logic [2:0]        cache_req_typ_o;
  logic              cache_req_phys_o;
  logic [DATA_W-1:0] cache_req_data_o;
  logic              cache_resp_valid_i, cache_resp_nack_i;
  logic [TAG_W-1:0]  cache_resp_tag_i;
  logic              cache_resp_has_data_i;
  logic [DATA_W-1:0] cache_resp_data_i;
  logic              acc_resp_valid_o;
  logic [TAG_W-1:0]  acc_resp_tag_o;
  logic [4:0]        acc_resp_cmd_o;
  logic              acc_resp_has_data_o;
  logic [DATA_W-1:0] acc_resp_data_o;
  logic              busy_o;
  logic [15:0]       nack_cnt_o;
  logic              err_o;

  rocc_mem_replay_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .acc_req_valid_i(acc_req_valid_i), .acc_req_ready_o(acc_req_ready_o),
    .acc_req_addr_i(acc_req_addr_i), .acc_req_tag_i(acc_req_tag_i),
    .acc_req_cmd_i(acc_req_cmd_i), .acc_req_typ_i(acc_req_typ_i),
    .acc_req_phys_i(acc_req_phys_i), .acc_req_data_i(acc_req_data_i),
    .cache_req_valid_o(cache_req_valid_o), .cache_req_ready_i(cache_req_ready_i),
    .cache_req_addr_o(cache_req_addr_o), .cache_req_tag_o(cache_req_tag_o),
    .cache_req_cmd_o(cache_req_cmd_o), .cache_req_typ_o(cache_req_typ_o),
    .cache_req_phys_o(cache_req_phys_o), .cache_req_data_o(cache_req_data_o),
    .cache_resp_valid_i(cache_resp_valid_i), .cache_resp_nack_i(cache_resp_nack_i),
    .cache_resp_tag_i(cache_resp_tag_i), .cache_resp_has_data_i(cache_resp_has_data_i),
    .cache_resp_data_i(cache_resp_data_i),
    .acc_resp_valid_o(acc_resp_valid_o), .acc_resp_tag_o(acc_resp_tag_o),
    .acc_resp_cmd_o(acc_resp_cmd_o), .acc_resp_has_data_o(acc_resp_has_data_o),
    .acc_resp_data_o(acc_resp_data_o),
    .busy_o(busy_o), .nack_cnt_o(nack_cnt_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle view of the cache request side and status outputs
  typedef struct {
    int          cyc;
    logic        req_valid;
    logic [39:0] addr;
    logic [9:0]  tag;
    logic [8:0]  ctl;
    logic [63:0] data;
    logic        ready;
    logic        busy;
    logic        err;
    logic [15:0] nacks;
  } cycle_exp_t;

  // Expected forwarded response, due on a specific cycle
  typedef struct {
    int          due;
    logic [9:0]  tag;
    logic [4:0]  cmd;
    logic        has_data;
    logic [63:0] data;
  } resp_exp_t;

  cycle_exp_t cq[$];
  resp_exp_t  aq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one record per entry slot
  bit          m_busy [DEPTH];
  bit          m_pend [DEPTH];
  logic [39:0] m_addr [DEPTH];
  logic [9:0]  m_tag  [DEPTH];
  logic [4:0]  m_cmd  [DEPTH];
  logic [2:0]  m_typ  [DEPTH];
  bit          m_phys [DEPTH];
  logic [63:0] m_data [DEPTH];
  bit          m_err;
  int          m_nacks;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int first_free();
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int first_pend();
    for (int i = 0; i < DEPTH; i++) if (m_busy[i] && m_pend[i]) return i;
    return -1;
  endfunction

  // Mostly target an in-flight entry, otherwise any index including out-of-range ones
  function automatic int pick_tag();
    int cand[$];
    if ($urandom_range(99) < 85) begin
      for (int i = 0; i < DEPTH; i++) if (m_busy[i] && !m_pend[i]) cand.push_back(i);
      if (cand.size() > 0) return cand[$urandom_range(cand.size() - 1)];
    end
    return $urandom_range(DEPTH + 1);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 0;
      m_pend[i] = 0;
    end
    m_err   = 0;
    m_nacks = 0;
  endtask

  // One clock cycle of stimulus; expectations are queued before the model advances
  task automatic apply_stimulus(input int preq, input int prdy, input int presp, input bit do_reset);
    cycle_exp_t e;
    resp_exp_t  r;
    int         fa, fp, t;
    bit         ok, alloc, issue;
    logic [63:0] wide;
    @(posedge clk);
    #1;
    cyc++;
    acc_req_valid_i    = 1'b0;
    cache_req_ready_i  = 1'b0;
    cache_resp_valid_i = 1'b0;
    cache_resp_nack_i  = 1'b0;
    e = '{cyc: cyc, req_valid: 0, addr: '0, tag: '0, ctl: '0, data: '0,
          ready: 0, busy: 0, err: 0, nacks: '0};
    if (do_reset) begin
      rst = 1'b1;
      model_clear();
      aq.delete();
      cq.push_back(e);
      return;
    end
    rst = 1'b0;

    fa = first_free();
    fp = first_pend();
    e.ready = (fa >= 0);
    e.busy  = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) e.busy = 1;
    e.err   = m_err;
    e.nacks = 16'(m_nacks);
    if (fp >= 0) begin
      e.req_valid = 1;
      e.addr      = m_addr[fp];
      e.tag       = 10'(fp);
      e.ctl       = {m_cmd[fp], m_typ[fp], m_phys[fp]};
      e.data      = m_data[fp];
    end
    cq.push_back(e);

    acc_req_valid_i = ($urandom_range(99) < preq);
    wide            = {$urandom, $urandom};
    acc_req_addr_i  = wide[39:0];
    acc_req_tag_i   = 10'($urandom);
    acc_req_cmd_i   = 5'($urandom);
    acc_req_typ_i   = 3'($urandom);
    acc_req_phys_i  = 1'($urandom);
    acc_req_data_i  = {$urandom, $urandom};
    cache_req_ready_i = ($urandom_range(99) < prdy);
    if ($urandom_range(99) < presp) begin
      t = pick_tag();
      cache_resp_nack_i  = ($urandom_range(3) == 0);
      cache_resp_valid_i = cache_resp_nack_i ? 1'($urandom) : 1'b1;
      cache_resp_tag_i   = 10'(t);
    end else begin
      t = 0;
      cache_resp_tag_i = 10'($urandom);
    end
    cache_resp_has_data_i = 1'($urandom);
    cache_resp_data_i     = {$urandom, $urandom};

    alloc = acc_req_valid_i && (fa >= 0);
    issue = (fp >= 0) && cache_req_ready_i;
    ok    = (cache_resp_tag_i < DEPTH) && m_busy[t] && !m_pend[t];
    if ((cache_resp_valid_i || cache_resp_nack_i) && !ok) m_err = 1;
    if (cache_resp_valid_i && !cache_resp_nack_i && ok) begin
      r = '{due: cyc + 1, tag: m_tag[t], cmd: m_cmd[t],
            has_data: cache_resp_has_data_i, data: cache_resp_data_i};
      aq.push_back(r);
      m_busy[t] = 0;
    end
    if (cache_resp_nack_i && ok) begin
      m_pend[t] = 1;
      if (m_nacks < 65535) m_nacks++;
    end
    if (issue) m_pend[fp] = 0;
    if (alloc) begin
      m_busy[fa] = 1;
      m_pend[fa] = 1;
      m_addr[fa] = acc_req_addr_i;
      m_tag[fa]  = acc_req_tag_i;
      m_cmd[fa]  = acc_req_cmd_i;
      m_typ[fa]  = acc_req_typ_i;
      m_phys[fa] = acc_req_phys_i;
      m_data[fa] = acc_req_data_i;
    end
  endtask

  // Monitor: compare the cycle's expectation and any forwarded response mid-cycle
  initial begin
    cycle_exp_t e;
    resp_exp_t  r;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        e = cq.pop_front();
        check_output("cache_req_valid", 64'(cache_req_valid_o), 64'(e.req_valid));
        check_output("acc_req_ready", 64'(acc_req_ready_o), 64'(e.ready));
        check_output("busy", 64'(busy_o), 64'(e.busy));
        check_output("err", 64'(err_o), 64'(e.err));
        check_output("nack_cnt", 64'(nack_cnt_o), 64'(e.nacks));
        if (e.req_valid) begin
          check_output("cache_req_addr", 64'(cache_req_addr_o), 64'(e.addr));
          check_output("cache_req_tag", 64'(cache_req_tag_o), 64'(e.tag));
          check_output("cache_req_ctl", 64'({cache_req_cmd_o, cache_req_typ_o, cache_req_phys_o}), 64'(e.ctl));
          check_output("cache_req_data", cache_req_data_o, e.data);
        end
      end
      if (acc_resp_valid_o) begin
        if (aq.size() == 0 || aq[0].due != cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL acc_resp_unexpected cycle %0d actual tag=%h expected no response", cyc, acc_resp_tag_o);
        end else begin
          r = aq.pop_front();
          check_output("acc_resp_tag", 64'(acc_resp_tag_o), 64'(r.tag));
          check_output("acc_resp_cmd", 64'(acc_resp_cmd_o), 64'(r.cmd));
          check_output("acc_resp_has_data", 64'(acc_resp_has_data_o), 64'(r.has_data));
          check_output("acc_resp_data", acc_resp_data_o, r.data);
        end
      end else if (aq.size() > 0 && aq[0].due <= cyc) begin
        r = aq.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL acc_resp_missing cycle %0d actual valid=0 expected tag=%h", cyc, r.tag);
      end
    end
  end

  // Driver: reset, then phases with different request, ready and response mixes
  initial begin
    int preq [4] = '{70, 90, 60, 50};
    int prdy [4] = '{80, 0, 30, 100};
    int presp[4] = '{40, 20, 50, 60};
    rst = 1'b1;
    acc_req_valid_i = 0; acc_req_addr_i = '0; acc_req_tag_i = '0; acc_req_cmd_i = '0;
    acc_req_typ_i = '0; acc_req_phys_i = 0; acc_req_data_i = '0;
    cache_req_ready_i = 0; cache_resp_valid_i = 0; cache_resp_nack_i = 0;
    cache_resp_tag_i = '0; cache_resp_has_data_i = 0; cache_resp_data_i = '0;
    model_clear();
    apply_stimulus(0, 0, 0, 1'b1);
    apply_stimulus(0, 0, 0, 1'b1);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 400; k++) begin
        apply_stimulus(preq[p], prdy[p], presp[p], ($urandom_range(149) == 0));
      end
      $display("[TB] phase %0d done, checks so far %0d", p, checks);
    end
    for (int k = 0; k < 4; k++) apply_stimulus(0, 100, 0, 1'b0);
    @(negedge clk);
    #1;
    check_output("acc_resp_queue_drained", 64'(aq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rocc_mem_replay_buf.md
Name: rocc_mem_replay_buf

Overview:
- Sits directly downstream of the vv_add accelerator's memory request/response port, between it and the L1 data cache.
- Buffers up to DEPTH outstanding requests and renames tags to entry indices.
- Re-issues any request the cache nacks, and maps responses back to the accelerator's original tag.
- Lets vv_add issue requests without tracking nack/replay itself.

Parameters:
DEPTH, 4, outstanding-request entries; power of 2, 2..16
ADDR_W, 40, request/response address width
TAG_W, 10, tag width; must be at least log2(DEPTH)
DATA_W, 64, data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
acc_req_valid_i  in  1  request valid from vv_add
acc_req_ready_o  out  1  request accepted this cycle when high together with valid
acc_req_addr_i  in  ADDR_W  address
acc_req_tag_i  in  TAG_W  accelerator tag
acc_req_cmd_i  in  5  memory command
acc_req_typ_i  in  3  access size/type
acc_req_phys_i  in  1  physical-address flag
acc_req_data_i  in  DATA_W  store data
cache_req_valid_o  out  1  request valid to cache
cache_req_ready_i  in  1  cache accepts request
cache_req_addr_o  out  ADDR_W  address
cache_req_tag_o  out  TAG_W  entry index, zero-extended
cache_req_cmd_o  out  5  command
cache_req_typ_o  out  3  type
cache_req_phys_o  out  1  phys flag
cache_req_data_o  out  DATA_W  store data
cache_resp_valid_i  in  1  response valid
cache_resp_nack_i  in  1  request identified by tag was rejected
cache_resp_tag_i  in  TAG_W  entry index
cache_resp_has_data_i  in  1  response carries load data
cache_resp_data_i  in  DATA_W  load data
acc_resp_valid_o  out  1  response to vv_add; no backpressure
acc_resp_tag_o  out  TAG_W  original accelerator tag
acc_resp_cmd_o  out  5  original command
acc_resp_has_data_o  out  1  load data present
acc_resp_data_o  out  DATA_W  load data
busy_o  out  1  at least one entry occupied
nack_cnt_o  out  16  saturating count of nacks
err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset clears every entry's busy and pending bits, acc_resp_valid_o, nack_cnt_o and err_o. All outputs read 0 during reset.
- Reset mid-operation discards all in-flight entries; no response is forwarded for them.
- Entry state: busy, pending, addr, tag, cmd, typ, phys, data.
  - Free: busy=0.
  - Awaiting issue: busy=1, pending=1.
  - In flight: busy=1, pending=0.
- Allocation:
  - acc_req_ready_o = any entry with busy=0, computed from registered state only.
  - On acc_req_valid_i & acc_req_ready_o, the lowest-index free entry captures all fields and sets busy=1, pending=1.
  - An entry freed this cycle is allocatable from the next cycle, never the same cycle.
- Issue:
  - cache_req_valid_o = any pending entry. This path is combinational from registers.
  - The lowest-index pending entry drives cache_req_*; cache_req_tag_o = its index.
  - On cache_req_valid_o & cache_req_ready_i, that entry's pending clears.
  - Outputs stay stable while valid is high and ready is low, unless a lower-index entry becomes pending. A newly allocated entry is pending only from the cycle after the handshake.
  - Zero-latency pass-through is not supported. Minimum request-to-cache latency is 1 cycle.
- Response, cache_resp_valid_i=1 and cache_resp_nack_i=0, index = cache_resp_tag_i:
  - If the entry is busy and not pending: next cycle, acc_resp_valid_o=1 with the stored tag and cmd, plus has_data and data from the cache.
  - The entry frees at the same edge, i.e. busy=0 one cycle after the response.
  - Store responses (has_data=0) also retire the entry.
  - acc_resp_valid_o is a 1-cycle pulse per response.
- Nack, cache_resp_nack_i=1, independent of cache_resp_valid_i:
  - If the entry is busy and not pending, set pending=1 so it re-issues with identical fields.
  - nack_cnt_o increments and saturates at 0xFFFF.
  - Nothing is forwarded to vv_add.
- Errors: a response or nack whose index is ≥ DEPTH, or targets a free or pending entry, is ignored and sets err_o until reset.
- Simultaneous events:
  - Issue handshake and nack on different entries in the same cycle are both applied.
  - A nack on the entry currently being issued cannot occur, because that entry is pending, so it is the error case.
  - Allocation, issue, response and nack on distinct entries in one cycle are all applied.
- busy_o = OR of all busy bits.

Test Plan:
- Single load: addr=0x100, tag=0x2A, cache ready, respond tag 0 with data 0xDEAD after 3 cycles -> cache_req_tag_o=0; acc_resp_valid_o one cycle after the response with tag 0x2A, data 0xDEAD; busy_o falls the same cycle.
- Fill: 5 back-to-back requests with cache_req_ready_i=0 -> acc_req_ready_o low after 4 accepts; the 5th is accepted the cycle after the first retire.
- Nack replay: issue tag-0 request, nack tag 0 -> identical request re-issued (same addr and data, cache tag 0); nack_cnt_o=1; a single acc response after the final response.
- Out-of-order: issue entries 0,1,2, respond 2,0,1 -> acc tags are returned in the order 2,0,1 with the correct original tags.
- Stall: cache_req_ready_i=0 for 10 cycles with a request pending -> cache_req_* outputs are stable; the handshake occurs only when ready rises.
- Error and reset: response to free entry 3 -> err_o=1, no acc response; then assert rst with 2 in flight -> busy_o=0, err_o=0, no later responses forwarded.
